// File: rtl/kpd_pkg.sv
// Shared keypad definitions: debounce FSM states and default key/code geometry.
package kpd_pkg;

  localparam int unsigned KPD_N_KEYS = 10;
  localparam int unsigned KPD_CODE_W = 4;

  typedef enum logic [1:0] {
    StIdle,
    StDebPress,
    StPressed,
    StDebRelease
  } kpd_state_e;

endpackage

// File: rtl/prio_enc.sv
// Combinational highest-index-wins priority encoder for a key vector.
module prio_enc
  import kpd_pkg::*;
#(
  parameter int unsigned N_KEYS = KPD_N_KEYS,
  parameter int unsigned CODE_W = KPD_CODE_W
) (
  input  logic [N_KEYS-1:0] i_vec,
  output logic              o_any,
  output logic [CODE_W-1:0] o_idx
);

  always_comb begin
    o_any = |i_vec;
    o_idx = '0;
    // Ascending scan so the last (highest) set bit overrides lower ones
    for (int unsigned i = 0; i < N_KEYS; i++) begin
      if (i_vec[i]) begin
        o_idx = CODE_W'(i);
      end
    end
  end

endmodule

// File: rtl/keypad_priority_encoder.sv
// Keypad front end: synchronise, debounce, priority-encode, strobe and buffer entered digits.
module keypad_priority_encoder
  import kpd_pkg::*;
#(
  parameter int unsigned N_KEYS          = KPD_N_KEYS,
  parameter int unsigned CODE_W          = KPD_CODE_W,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned DEPTH           = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_KEYS-1:0]            keys_in,
  input  logic                         enable_n,
  input  logic                         clear,
  output logic [CODE_W-1:0]            key_code,
  output logic                         key_valid,
  output logic                         key_held,
  output logic [DEPTH*CODE_W-1:0]      digits,
  output logic [$clog2(DEPTH+1)-1:0]   digit_count,
  output logic                         buf_full,
  output logic                         overflow
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned DC_W  = $clog2(DEPTH + 1);
  localparam int unsigned DW    = DEPTH * CODE_W;
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DC_W-1:0]  CountMax = DC_W'(DEPTH);

  logic [N_KEYS-1:0] r_sync1, r_sync2;
  kpd_state_e        r_state, w_state_next;
  logic [CNT_W-1:0]  r_cnt, w_cnt_next;
  logic [CODE_W-1:0] r_cand, w_cand_next;
  logic              r_acc, w_accept;
  logic              w_any;
  logic [CODE_W-1:0] w_idx;

  logic [CODE_W-1:0] r_key_code;
  logic              r_key_valid, r_key_held, r_overflow;
  logic [DW-1:0]     r_digits;
  logic [DC_W-1:0]   r_count;
  logic              w_full;

  prio_enc #(
    .N_KEYS(N_KEYS),
    .CODE_W(CODE_W)
  ) u_prio_enc (
    .i_vec(r_sync2),
    .o_any(w_any),
    .o_idx(w_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= keys_in;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_cand  <= '0;
      r_acc   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_cand  <= w_cand_next;
      r_acc   <= w_accept;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_cand_next  = r_cand;
    w_accept     = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_any && !enable_n) begin
          w_state_next = StDebPress;
          w_cand_next  = w_idx;
          w_cnt_next   = '0;
        end
      end
      StDebPress: begin
        if (!w_any || (w_idx != r_cand) || enable_n) begin
          w_state_next = StIdle;
        end else if (r_cnt == CntLast) begin
          w_state_next = StPressed;
          w_accept     = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      StPressed: begin
        if (!w_any) begin
          w_state_next = StDebRelease;
          w_cnt_next   = '0;
        end
      end
      StDebRelease: begin
        if (w_any) begin
          w_state_next = StPressed;
        end else if (r_cnt == CntLast) begin
          w_state_next = StIdle;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  assign w_full = (r_count == CountMax);

  // Accept actions run one cycle after the FSM commits, from the registered accept strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_code  <= '0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
      r_overflow  <= 1'b0;
      r_digits    <= '0;
      r_count     <= '0;
    end else begin
      r_key_valid <= 1'b0;
      r_overflow  <= 1'b0;
      r_key_held  <= (r_state == StPressed) || (r_state == StDebRelease);
      if (r_acc) begin
        r_key_valid <= 1'b1;
        r_key_code  <= r_cand;
        if (clear) begin
          r_digits <= DW'(r_cand);
          r_count  <= DC_W'(1);
        end else if (w_full) begin
          r_overflow <= 1'b1;
        end else begin
          r_digits <= (r_digits << CODE_W) | DW'(r_cand);
          r_count  <= r_count + 1'b1;
        end
      end else if (clear) begin
        r_digits <= '0;
        r_count  <= '0;
      end
    end
  end

  assign key_code    = r_key_code;
  assign key_valid   = r_key_valid;
  assign key_held    = r_key_held;
  assign digits      = r_digits;
  assign digit_count = r_count;
  assign buf_full    = w_full;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_keypad_priority_encoder.sv
// Self-checking bench for keypad_priority_encoder: vector table, corner sequences, random stimulus.
module tb_keypad_priority_encoder;

  localparam int D     = 4;
  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic [9:0]  keys_in;
  logic        enable_n;
  logic        clear;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] digits;
  logic [2:0]  digit_count;
  logic        buf_full;
  logic        overflow;

  keypad_priority_encoder #(
    .N_KEYS(10),
    .CODE_W(4),
    .DEBOUNCE_CYCLES(D),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .keys_in(keys_in),
    .enable_n(enable_n),
    .clear(clear),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_held(key_held),
    .digits(digits),
    .digit_count(digit_count),
    .buf_full(buf_full),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n_valid, n_ovf;

  // Reference model: press/release run lengths plus a queue of entered digits
  logic [9:0] ms1, ms2;
  bit  m_pressed, m_pend, m_valid, m_ovf, m_held;
  int  m_streak, m_rel, m_cand, m_code;
  int  m_q[$];

  function automatic int highest(input logic [9:0] v);
    for (int i = 9; i >= 0; i--) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int packed_digits();
    int v = 0;
    for (int i = 0; i < m_q.size(); i++) v = v | (m_q[i] << (4 * i));
    return v;
  endfunction

  task automatic model_reset();
    ms1 = '0; ms2 = '0;
    m_pressed = 0; m_pend = 0; m_valid = 0; m_ovf = 0; m_held = 0;
    m_streak = 0; m_rel = 0; m_cand = 0; m_code = 0;
    m_q.delete();
  endtask

  task automatic model_step();
    int  h;
    bit  qual;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_valid = 0;
    m_ovf   = 0;
    m_held  = m_pressed;
    if (m_pend) begin
      m_valid = 1;
      m_code  = m_cand;
      if (clear) begin
        m_q.delete();
        m_q.push_front(m_cand);
      end else if (m_q.size() == DEPTH) begin
        m_ovf = 1;
      end else begin
        m_q.push_front(m_cand);
      end
    end else if (clear) begin
      m_q.delete();
    end
    m_pend = 0;
    h = highest(ms2);
    if (!m_pressed) begin
      qual = (h >= 0) && !enable_n;
      if (m_streak == 0) begin
        if (qual) begin
          m_cand   = h;
          m_streak = 1;
        end
      end else if (qual && h == m_cand) begin
        if (m_streak == D) begin
          m_pressed = 1; m_rel = 0; m_pend = 1; m_streak = 0;
        end else begin
          m_streak++;
        end
      end else begin
        m_streak = 0;
      end
    end else begin
      if (h >= 0) m_rel = 0;
      else if (m_rel == D) m_pressed = 0;
      else m_rel++;
    end
    ms2 = ms1;
    ms1 = keys_in;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check("key_code", 32'(key_code), m_code);
    check("key_valid", 32'(key_valid), 32'(m_valid));
    check("key_held", 32'(key_held), 32'(m_held));
    check("digits", 32'(digits), packed_digits());
    check("digit_count", 32'(digit_count), m_q.size());
    check("buf_full", 32'(buf_full), 32'(m_q.size() == DEPTH));
    check("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (key_valid) n_valid++;
    if (overflow) n_ovf++;
    check_all();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_code"}, 32'(key_code), 0);
    check({tag, "_valid"}, 32'(key_valid), 0);
    check({tag, "_held"}, 32'(key_held), 0);
    check({tag, "_digits"}, 32'(digits), 0);
    check({tag, "_count"}, 32'(digit_count), 0);
    check({tag, "_ovf"}, 32'(overflow), 0);
  endtask

  typedef struct {
    logic [9:0]  keys;
    int          hold;
    int          rel;
    bit          en_n;
    int          exp_pulses;
    int          exp_ovf;
    logic [3:0]  exp_code;
    logic [15:0] exp_digits;
    int          exp_count;
  } vec_t;

  vec_t vecs[$];

  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_zero(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic latency_check(input string tag, input logic [3:0] code);
    n_valid = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 7) check({tag, "_early"}, 32'(key_valid), 0);
      if (k == 8) check({tag, "_pulse"}, 32'(key_valid), 1);
    end
    check({tag, "_code"}, 32'(key_code), 32'(code));
  endtask

  initial begin
    rst_n = 1'b0; keys_in = '0; enable_n = 1'b0; clear = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    // Key 7: exact latency, then hold to 20 cycles and release
    keys_in = 10'h080;
    latency_check("t1", 4'd7);
    repeat (12) tick();
    check("t1_held", 32'(key_held), 1);
    keys_in = '0;
    repeat (12) tick();
    check("t1_pulses", n_valid, 1);
    check("t1_digits", 32'(digits), 32'h0007);

    vecs.push_back('{10'h204, 20, 12, 1'b0, 1, 0, 4'd9, 16'h0079, 2});
    for (int r = 0; r < 3; r++) vecs.push_back('{10'h020, 2, 3, 1'b0, 0, 0, 4'd9, 16'h0079, 2});
    for (int r = 0; r < vecs.size(); r++) begin
      n_valid = 0; n_ovf = 0;
      enable_n = vecs[r].en_n;
      keys_in  = vecs[r].keys;
      repeat (vecs[r].hold) tick();
      keys_in = '0;
      repeat (vecs[r].rel) tick();
      enable_n = 1'b0;
      check($sformatf("v%0d_pulses", r), n_valid, vecs[r].exp_pulses);
      check($sformatf("v%0d_ovf", r), n_ovf, vecs[r].exp_ovf);
      check($sformatf("v%0d_code", r), 32'(key_code), 32'(vecs[r].exp_code));
      check($sformatf("v%0d_digits", r), 32'(digits), 32'(vecs[r].exp_digits));
      check($sformatf("v%0d_count", r), 32'(digit_count), vecs[r].exp_count);
    end

    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_digits", 32'(digits), 0);
    check("clr_count", 32'(digit_count), 0);

    vecs.delete();
    vecs.push_back('{10'h002, 20, 12, 1'b0, 1, 0, 4'd1, 16'h0001, 1});
    vecs.push_back('{10'h004, 20, 12, 1'b0, 1, 0, 4'd2, 16'h0012, 2});
    vecs.push_back('{10'h008, 20, 12, 1'b0, 1, 0, 4'd3, 16'h0123, 3});
    vecs.push_back('{10'h010, 20, 12, 1'b0, 1, 0, 4'd4, 16'h1234, 4});
    vecs.push_back('{10'h020, 20, 12, 1'b0, 1, 1, 4'd5, 16'h1234, 4});
    vecs.push_back('{10'h008, 20, 12, 1'b1, 0, 0, 4'd5, 16'h1234, 4});
    for (int r = 0; r < vecs.size(); r++) begin
      n_valid = 0; n_ovf = 0;
      enable_n = vecs[r].en_n;
      keys_in  = vecs[r].keys;
      repeat (vecs[r].hold) tick();
      keys_in = '0;
      repeat (vecs[r].rel) tick();
      enable_n = 1'b0;
      check($sformatf("s%0d_pulses", r), n_valid, vecs[r].exp_pulses);
      check($sformatf("s%0d_ovf", r), n_ovf, vecs[r].exp_ovf);
      check($sformatf("s%0d_code", r), 32'(key_code), 32'(vecs[r].exp_code));
      check($sformatf("s%0d_digits", r), 32'(digits), 32'(vecs[r].exp_digits));
      check($sformatf("s%0d_count", r), 32'(digit_count), vecs[r].exp_count);
      if (r == 3) check("s3_full", 32'(buf_full), 1);
    end

    // Release glitch while held must not re-strobe
    n_valid = 0;
    keys_in = 10'h100;
    repeat (12) tick();
    keys_in = '0;
    repeat (2) tick();
    keys_in = 10'h100;
    repeat (10) tick();
    keys_in = '0;
    repeat (12) tick();
    check("glitch_pulses", n_valid, 1);
    check("glitch_code", 32'(key_code), 8);

    // Clear coinciding with the accept of key 6
    keys_in = 10'h040;
    begin
      int k = 0;
      while (!m_pend && k < 30) begin
        tick();
        k++;
      end
      check("clracc_reached", 32'(m_pend), 1);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clracc_digits", 32'(digits), 32'h0006);
    check("clracc_count", 32'(digit_count), 1);
    check("clracc_ovf", 32'(overflow), 0);
    keys_in = '0;
    repeat (12) tick();

    // Reset during DEB_PRESS, then during PRESSED; held key must re-debounce fully
    keys_in = 10'h004;
    repeat (4) tick();
    pulse_reset("rst_deb");
    latency_check("rst_deb", 4'd2);
    repeat (6) tick();
    pulse_reset("rst_prs");
    latency_check("rst_prs", 4'd2);
    check("rst_prs_digits", 32'(digits), 32'h0002);
    keys_in = '0;
    repeat (12) tick();

    for (int it = 0; it < 300; it++) begin
      int sel = int'($urandom_range(0, 3));
      if (sel == 0) keys_in = '0;
      else if (sel == 1) keys_in = 10'(1 << $urandom_range(0, 9));
      else keys_in = 10'($urandom);
      enable_n = ($urandom_range(0, 7) == 0);
      clear    = ($urandom_range(0, 15) == 0);
      tick();
      clear = 1'b0;
      repeat ($urandom_range(0, 11)) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad_priority_encoder.md
Name: keypad_priority_encoder

Overview:
Parametrised, clocked successor to the team's 10-line-to-BCD keypad encoder. Functions:
- Synchronises and debounces a one-hot-ish keypad vector.
- Performs true highest-index-wins priority encoding.
- Emits a one-cycle key strobe per debounced press.
- Accumulates pressed digits in a small shift buffer for the downstream controller (code entry/compare logic).

Parameters:
N_KEYS, 10, number of key lines; key i encodes to value i.
CODE_W, 4, width of an encoded key; must satisfy 2**CODE_W >= N_KEYS.
DEBOUNCE_CYCLES, 16, consecutive stable cycles required for press and for release; >= 1.
DEPTH, 4, number of digits held in the entry buffer; >= 1.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
keys_in  in  N_KEYS  raw key lines, active-high, asynchronous to clk
enable_n  in  1  active-low enable; high blocks new presses
clear  in  1  synchronous clear of the digit buffer
key_code  out  CODE_W  code of last accepted key; held until next accept
key_valid  out  1  one-cycle pulse on each accepted press
key_held  out  1  high from accept until release debounce completes
digits  out  DEPTH*CODE_W  buffer; newest digit at bits [CODE_W-1:0]
digit_count  out  $clog2(DEPTH+1)  digits stored, saturates at DEPTH
buf_full  out  1  digit_count == DEPTH
overflow  out  1  one-cycle pulse when an accept is dropped because the buffer is full

Behaviour:
- Reset (async, rst_n low): all outputs 0, synchroniser flops 0, FSM IDLE, counter 0, buffer 0. Reset mid-press aborts everything. After release of reset, a still-held key is treated as a fresh press and must debounce fully.
- Synchroniser: 2 flops per key line. Encoder works only on the synchronised vector ks.
- Encoding: any = OR(ks); idx = highest set bit index of ks. Multiple keys always resolve to the highest index.
- FSM states:
  - IDLE: if any && !enable_n -> DEB_PRESS; cand <= idx; cnt <= 0.
  - DEB_PRESS:
    - if !any || idx != cand || enable_n -> IDLE (abort, no strobe).
    - else if cnt == DEBOUNCE_CYCLES-1 -> PRESSED (accept).
    - else cnt++.
  - PRESSED: key_held=1. Other key changes are ignored (no rollover). If !any -> DEB_RELEASE; cnt <= 0.
  - DEB_RELEASE:
    - if any -> PRESSED (bounce, no new strobe).
    - else if cnt == DEBOUNCE_CYCLES-1 -> IDLE.
    - else cnt++.
  - enable_n does not affect PRESSED or DEB_RELEASE; a held key always runs to release.
- Accept actions (registered):
  - key_valid=1 for exactly one cycle; key_code <= cand.
  - If !buf_full: digits <= {digits << CODE_W} | cand; digit_count++.
  - If buf_full: digits and count unchanged; overflow=1 for one cycle.
- Latency: key stable from sampling edge E0 -> key_valid high in the cycle after edge E0+DEBOUNCE_CYCLES+3.
- clear: next edge digits=0, digit_count=0; key_code unchanged. Clear and accept in the same cycle -> buffer holds only the new digit, digit_count=1, no overflow.
- Widths: cnt is $clog2(DEBOUNCE_CYCLES+1) bits and never wraps. digit_count never exceeds DEPTH.

Decomposition:
- Shared package kpd_pkg: FSM state enum (IDLE, DEB_PRESS, PRESSED, DEB_RELEASE); default N_KEYS/CODE_W constants.
- One sub-module, prio_enc (combinational, parametrised N_KEYS/CODE_W), outputs any and idx. Reused by other keypad consumers.

Test Plan:
(all with N_KEYS=10, CODE_W=4, DEBOUNCE_CYCLES=4, DEPTH=4)
1. keys_in=0x080 (key 7) held 20 cycles -> key_valid single pulse 7 edges after first sample; key_code=7, digits=0x0007, digit_count=1, key_held high until 4 cycles after release reaches ks.
2. keys_in=0x204 (keys 9 and 2) together -> key_code=9, one pulse only.
3. key 5 high for 2 cycles then low; repeat 3 times -> no key_valid, buffer unchanged. Release glitch of 2 cycles while held -> no second pulse.
4. Press 1, 2, 3, 4, 5 sequentially -> digits=0x1234, buf_full=1 after 4th; 5th gives key_valid and overflow pulses, digits stays 0x1234.
5. enable_n=1 during press of key 3 -> no accept. Assert clear the same cycle as accepting key 6 with 0x1234 stored -> digits=0x0006, digit_count=1.
6. rst_n low for 1 cycle while in DEB_PRESS, and again while PRESSED -> outputs 0 immediately; key still held after reset -> new accept after full debounce.
